// File: rtl/registro_universal_param_pkg.sv
// Shared definitions for registro_universal_param and its shadow bank.
// Contents:
//   state_e         - controller state encoding (LIVE / CAPTURE / FROZEN)
//   DEF_*           - default WIDTH / N_CH / SEL_W values
//   sel_in_range()  - channel index range check
// Optional feature macro used by the importing files: REG_UNIV_PARITY_EN
package registro_universal_param_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N_CH  = 2;
    localparam int unsigned DEF_SEL_W = 1;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_LIVE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_e;

    // True when a zero-extended channel index addresses an existing channel.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_ch);
        return (sel < n_ch);
    endfunction

endpackage : registro_universal_param_pkg

// File: rtl/registro_shadow_bank.sv
// Snapshot bank: N_CH words of WIDTH bits, all loaded in parallel on one falling
// edge, read back through an asynchronous mux.
// Ports:
//   clk        in   falling-edge clock
//   reset      in   asynchronous active-high reset, clears every word
//   i_load     in   1 = load every channel from i_dato on this edge
//   i_dato     in   N_CH*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   i_rd_sel   in   read index
//   o_rd_dato  out  word selected by i_rd_sel (0 if out of range)
//   o_rd_par   out  stored parity of the selected word (REG_UNIV_PARITY_EN only)
module registro_shadow_bank
    import registro_universal_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [N_CH*WIDTH-1:0] i_dato,
    input  logic [SEL_W-1:0]      i_rd_sel,
    output logic [WIDTH-1:0]      o_rd_dato
`ifdef REG_UNIV_PARITY_EN
    ,
    output logic                  o_rd_par
`endif
);

    logic [WIDTH-1:0] r_mem [N_CH];
`ifdef REG_UNIV_PARITY_EN
    logic             r_par [N_CH];
`endif

    // Parallel snapshot of every channel.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                r_mem[k] <= '0;
`ifdef REG_UNIV_PARITY_EN
                r_par[k] <= 1'b0;
`endif
            end
        end else if (i_load) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                r_mem[k] <= i_dato[k*WIDTH +: WIDTH];
`ifdef REG_UNIV_PARITY_EN
                r_par[k] <= ^i_dato[k*WIDTH +: WIDTH];
`endif
            end
        end
    end

    // Compare-based read mux so unused codes of i_rd_sel never index past the array.
    always_comb begin
        o_rd_dato = '0;
`ifdef REG_UNIV_PARITY_EN
        o_rd_par  = 1'b0;
`endif
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (i_rd_sel == SEL_W'(k)) begin
                o_rd_dato = r_mem[k];
`ifdef REG_UNIV_PARITY_EN
                o_rd_par  = r_par[k];
`endif
            end
        end
    end

endmodule : registro_shadow_bank

// File: rtl/registro_universal_param.sv
// Channel-select output register with an atomic snapshot (frozen) mode.
// One of N_CH channels is loaded into out_dato on the falling clock edge; a capture
// request latches all channels at once so multi-field values are read coherently
// while the live sources keep changing.
// Ports:
//   clk          in   falling-edge clock
//   reset        in   asynchronous active-high reset
//   hold         in   1 = output register keeps its value
//   capture      in   1-cycle request: snapshot all channels, enter frozen mode
//   release_req  in   1-cycle request: leave frozen mode, return to live
//   chip_select  in   channel index
//   in_dato      in   N_CH*WIDTH packed channels
//   out_dato     out  registered output word
//   out_valid    out  out_dato holds a loaded value
//   frozen       out  output sourced from the snapshot bank (CAPTURE or FROZEN)
//   changed      out  1-cycle pulse: last load changed out_dato
//   sel_err      out  chip_select >= N_CH on the last edge (or shadow parity error)
//   out_par      out  even parity of out_dato (REG_UNIV_PARITY_EN only)
// Optional feature macro: REG_UNIV_PARITY_EN
module registro_universal_param
    import registro_universal_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  capture,
    input  logic                  release_req,
    input  logic [SEL_W-1:0]      chip_select,
    input  logic [N_CH*WIDTH-1:0] in_dato,
    output logic [WIDTH-1:0]      out_dato,
    output logic                  out_valid,
    output logic                  frozen,
    output logic                  changed,
    output logic                  sel_err
`ifdef REG_UNIV_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    state_e           r_state;
    state_e           w_next_state;

    logic [WIDTH-1:0] r_dato;
    logic             r_valid;
    logic             r_frozen;
    logic             r_changed;
    logic             r_sel_err;

    logic             w_sel_ok;
    logic             w_load;
    logic             w_snap;
    logic             w_sel_err;
    logic [WIDTH-1:0] w_live_dato;
    logic [WIDTH-1:0] w_shadow_dato;
    logic [WIDTH-1:0] w_src;

`ifdef REG_UNIV_PARITY_EN
    logic             r_par;
    logic             w_shadow_par;
`endif

    registro_shadow_bank #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_snap),
        .i_dato    (in_dato),
        .i_rd_sel  (chip_select),
        .o_rd_dato (w_shadow_dato)
`ifdef REG_UNIV_PARITY_EN
        ,
        .o_rd_par  (w_shadow_par)
`endif
    );

    // State register.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LIVE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, load decision and output-register source select.
    always_comb begin
        w_next_state = r_state;
        w_live_dato  = '0;
        w_snap       = 1'b0;
        w_sel_ok     = sel_in_range(32'(chip_select), N_CH);
        w_load       = 1'b0;
        w_src        = r_dato;
        w_sel_err    = 1'b0;

        for (int unsigned k = 0; k < N_CH; k++) begin
            if (chip_select == SEL_W'(k)) begin
                w_live_dato = in_dato[k*WIDTH +: WIDTH];
            end
        end

        // capture has priority over release when both are requested.
        case (r_state)
            ST_LIVE: begin
                if (capture) begin
                    w_next_state = ST_CAPTURE;
                end
                w_src  = w_live_dato;
                w_load = !hold && w_sel_ok;
            end
            ST_CAPTURE: begin
                w_next_state = ST_FROZEN;
                w_snap       = 1'b1;
            end
            ST_FROZEN: begin
                if (capture) begin
                    w_next_state = ST_CAPTURE;
                end else if (release_req) begin
                    w_next_state = ST_LIVE;
                end
                w_src  = w_shadow_dato;
                w_load = !hold && w_sel_ok;
            end
            default: begin
                w_next_state = ST_LIVE;
            end
        endcase

        w_sel_err = !w_sel_ok;
`ifdef REG_UNIV_PARITY_EN
        // A corrupted shadow word is flagged on the same pulse as a bad index.
        if (w_load && (r_state == ST_FROZEN) && ((^w_shadow_dato) != w_shadow_par)) begin
            w_sel_err = 1'b1;
        end
`endif
    end

    // Output register and status flags.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_dato    <= '0;
            r_valid   <= 1'b0;
            r_frozen  <= 1'b0;
            r_changed <= 1'b0;
            r_sel_err <= 1'b0;
`ifdef REG_UNIV_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_frozen  <= (w_next_state != ST_LIVE);
            r_sel_err <= w_sel_err;
            r_changed <= w_load && (w_src != r_dato);
            if (w_load) begin
                r_dato <= w_src;
`ifdef REG_UNIV_PARITY_EN
                r_par  <= ^w_src;
`endif
            end
            // Validity is dropped while the snapshot is being taken.
            if (r_state == ST_CAPTURE) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign out_dato  = r_dato;
    assign out_valid = r_valid;
    assign frozen    = r_frozen;
    assign changed   = r_changed;
    assign sel_err   = r_sel_err;
`ifdef REG_UNIV_PARITY_EN
    assign out_par   = r_par;
`endif

endmodule : registro_universal_param

// File: tb/tb_registro_universal_param.sv
// Directed bench for registro_universal_param: a default instance (N_CH=2) and a
// three-channel instance (N_CH=3, SEL_W=2). Outputs are sampled 1 time unit after
// the active falling edge.
module tb_registro_universal_param;

    logic        clk;
    logic        reset;

    logic        hold2, cap2, rel2;
    logic [0:0]  sel2;
    logic [15:0] in2;
    logic [7:0]  out2;
    logic        val2, frz2, chg2, err2;

    logic        hold3, cap3, rel3;
    logic [1:0]  sel3;
    logic [23:0] in3;
    logic [7:0]  out3;
    logic        val3, frz3, chg3, err3;

`ifdef REG_UNIV_PARITY_EN
    logic        par2, par3;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    registro_universal_param dut2 (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold2),
        .capture     (cap2),
        .release_req (rel2),
        .chip_select (sel2),
        .in_dato     (in2),
        .out_dato    (out2),
        .out_valid   (val2),
        .frozen      (frz2),
        .changed     (chg2),
        .sel_err     (err2)
`ifdef REG_UNIV_PARITY_EN
        ,
        .out_par     (par2)
`endif
    );

    registro_universal_param #(.WIDTH(8), .N_CH(3), .SEL_W(2)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold3),
        .capture     (cap3),
        .release_req (rel3),
        .chip_select (sel3),
        .in_dato     (in3),
        .out_dato    (out3),
        .out_valid   (val3),
        .frozen      (frz3),
        .changed     (chg3),
        .sel_err     (err3)
`ifdef REG_UNIV_PARITY_EN
        ,
        .out_par     (par3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        hold2 = 1'b0; cap2 = 1'b0; rel2 = 1'b0; sel2 = 1'b0; in2 = 16'h0;
        hold3 = 1'b0; cap3 = 1'b0; rel3 = 1'b0; sel3 = 2'd0; in3 = 24'h0;
        #1;
        chk("rst_out",   32'(out2), 32'h0);
        chk("rst_valid", 32'(val2), 32'h0);
        chk("rst_frozen",32'(frz2), 32'h0);
        chk("rst_chg",   32'(chg2), 32'h0);
        chk("rst_err",   32'(err2), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Live loads on the default instance: ch0=15, ch1=42.
        in2 = {8'h42, 8'h15};
        sel2 = 1'b0;
        tick();
        chk("live_sel0_out", 32'(out2), 32'h15);
        chk("live_sel0_chg", 32'(chg2), 32'h1);
        chk("live_sel0_val", 32'(val2), 32'h1);
        chk("live_frozen",   32'(frz2), 32'h0);
        sel2 = 1'b1;
        tick();
        chk("live_sel1_out", 32'(out2), 32'h42);
        chk("live_sel1_chg", 32'(chg2), 32'h1);
        tick();
        chk("repeat_out", 32'(out2), 32'h42);
        chk("repeat_chg", 32'(chg2), 32'h0);

        // Hold keeps 15 while ch0 moves to 99.
        sel2 = 1'b0;
        tick();
        chk("reload15", 32'(out2), 32'h15);
        hold2 = 1'b1;
        in2 = {8'h42, 8'h99};
        tick();
        chk("hold_out", 32'(out2), 32'h15);
        chk("hold_chg", 32'(chg2), 32'h0);
        hold2 = 1'b0;
        tick();
        chk("unhold_out", 32'(out2), 32'h99);
        chk("unhold_chg", 32'(chg2), 32'h1);

        // Hold does not block the capture sequence.
        hold2 = 1'b1;
        cap2 = 1'b1;
        tick();
        chk("holdcap_frozen", 32'(frz2), 32'h1);
        chk("holdcap_out",    32'(out2), 32'h99);
        cap2 = 1'b0;
        tick();
        chk("holdcap_val", 32'(val2), 32'h0);
        in2 = {8'h11, 8'h22};
        hold2 = 1'b0;
        sel2 = 1'b1;
        tick();
        chk("holdcap_shadow", 32'(out2), 32'h42);
        chk("holdcap_val1",   32'(val2), 32'h1);
        rel2 = 1'b1;
        tick();
        rel2 = 1'b0;
        chk("rel2_frozen", 32'(frz2), 32'h0);
        sel2 = 1'b0;
        in2 = {8'h11, 8'h07};
        tick();
        chk("load07", 32'(out2), 32'h07);
`ifdef REG_UNIV_PARITY_EN
        chk("par07", 32'(par2), 32'h1);
`endif
        in2 = {8'h11, 8'h03};
        tick();
        chk("load03", 32'(out2), 32'h03);
`ifdef REG_UNIV_PARITY_EN
        chk("par03", 32'(par2), 32'h0);
`endif

        // Snapshot on the three-channel instance: ch = {30,59,12}.
        in3 = {8'h12, 8'h59, 8'h30};
        sel3 = 2'd0;
        cap3 = 1'b1;
        tick();
        chk("cap_frozen", 32'(frz3), 32'h1);
        chk("cap_out",    32'(out3), 32'h30);
        cap3 = 1'b0;
        tick();
        chk("capst_val",    32'(val3), 32'h0);
        chk("capst_chg",    32'(chg3), 32'h0);
        chk("capst_frozen", 32'(frz3), 32'h1);
        in3 = {8'h13, 8'h00, 8'h31};
        tick();
        chk("frz_sel0", 32'(out3), 32'h30);
        chk("frz_val",  32'(val3), 32'h1);
        sel3 = 2'd1;
        tick();
        chk("frz_sel1",     32'(out3), 32'h59);
        chk("frz_sel1_chg", 32'(chg3), 32'h1);
        sel3 = 2'd2;
        tick();
        chk("frz_sel2",   32'(out3), 32'h12);
        chk("frz_flag",   32'(frz3), 32'h1);
        rel3 = 1'b1;
        sel3 = 2'd0;
        tick();
        rel3 = 1'b0;
        chk("rel_frozen", 32'(frz3), 32'h0);
        chk("rel_out",    32'(out3), 32'h30);
        tick();
        chk("live_after_rel", 32'(out3), 32'h31);

        // Out-of-range index: output kept, one-edge error pulse.
        sel3 = 2'd3;
        tick();
        chk("selerr_out", 32'(out3), 32'h31);
        chk("selerr_err", 32'(err3), 32'h1);
        chk("selerr_chg", 32'(chg3), 32'h0);
        sel3 = 2'd2;
        tick();
        chk("selerr_clear", 32'(err3), 32'h0);
        chk("selerr_next",  32'(out3), 32'h13);

        // capture+release together: capture wins, from LIVE and from FROZEN.
        cap3 = 1'b1;
        rel3 = 1'b1;
        tick();
        chk("both_live_frozen", 32'(frz3), 32'h1);
        cap3 = 1'b0;
        rel3 = 1'b0;
        tick();
        chk("both_live_capst", 32'(val3), 32'h0);
        cap3 = 1'b1;
        rel3 = 1'b1;
        tick();
        chk("both_frz_frozen", 32'(frz3), 32'h1);
        cap3 = 1'b0;
        rel3 = 1'b0;
        tick();
        chk("both_frz_capst", 32'(val3), 32'h0);

        // Asynchronous reset mid-FROZEN, then a live load.
        sel3 = 2'd1;
        tick();
        chk("prerst_val", 32'(val3), 32'h1);
        chk("prerst_frz", 32'(frz3), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_out",    32'(out3), 32'h0);
        chk("async_frozen", 32'(frz3), 32'h0);
        chk("async_valid",  32'(val3), 32'h0);
        tick();
        reset = 1'b0;
        sel3 = 2'd0;
        tick();
        chk("postrst_out", 32'(out3), 32'h31);
        chk("postrst_frz", 32'(frz3), 32'h0);
        chk("postrst_val", 32'(val3), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_registro_universal_param
